// File: rtl/note_tone_gen_pkg.sv
// Shared definitions for the note tone generator.
// Holds the note codes (none, C4..C5), the half-period table in 100 MHz
// cycles, the one-hot Led patterns, the FSM state type and small lookup
// helpers that turn a note code into a half-period or a Led pattern.
package note_tone_gen_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd2;
  localparam logic [3:0] NOTE_E    = 4'd3;
  localparam logic [3:0] NOTE_F    = 4'd4;
  localparam logic [3:0] NOTE_G    = 4'd5;
  localparam logic [3:0] NOTE_A    = 4'd6;
  localparam logic [3:0] NOTE_B    = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;

  localparam int unsigned HP_C4 = 191113;
  localparam int unsigned HP_D  = 170265;
  localparam int unsigned HP_E  = 151685;
  localparam int unsigned HP_F  = 143172;
  localparam int unsigned HP_G  = 127551;
  localparam int unsigned HP_A  = 113636;
  localparam int unsigned HP_B  = 101239;
  localparam int unsigned HP_C5 = 95557;

  localparam logic [7:0] LED_C4 = 8'b0000_0001;
  localparam logic [7:0] LED_D  = 8'b0000_0010;
  localparam logic [7:0] LED_E  = 8'b0000_0100;
  localparam logic [7:0] LED_F  = 8'b0000_1000;
  localparam logic [7:0] LED_G  = 8'b0001_0000;
  localparam logic [7:0] LED_A  = 8'b0010_0000;
  localparam logic [7:0] LED_B  = 8'b0100_0000;
  localparam logic [7:0] LED_C5 = 8'b1000_0000;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_TONE   = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // Codes outside 1..8 mean silence.
  function automatic logic [3:0] note_norm(input logic [3:0] code);
    return ((code >= NOTE_C4) && (code <= NOTE_C5)) ? code : NOTE_NONE;
  endfunction

  function automatic int unsigned half_period(input logic [3:0] note);
    case (note)
      NOTE_C4: return HP_C4;
      NOTE_D:  return HP_D;
      NOTE_E:  return HP_E;
      NOTE_F:  return HP_F;
      NOTE_G:  return HP_G;
      NOTE_A:  return HP_A;
      NOTE_B:  return HP_B;
      NOTE_C5: return HP_C5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] note_led(input logic [3:0] note);
    case (note)
      NOTE_C4: return LED_C4;
      NOTE_D:  return LED_D;
      NOTE_E:  return LED_E;
      NOTE_F:  return LED_F;
      NOTE_G:  return LED_G;
      NOTE_A:  return LED_A;
      NOTE_B:  return LED_B;
      NOTE_C5: return LED_C5;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Pin bundle of the note tone generator.
//   note_in  4  note code from the beat-domain sequencer (asynchronous)
//   SPK      1  square-wave speaker drive
//   Led      8  one-hot of the sounding note, 0 when silent
//   playing  1  high while a tone is sounding
// master: the side that supplies note codes and observes the outputs.
// slave : the tone generator itself.
interface note_tone_gen_if;
  logic [3:0] note_in;
  logic       SPK;
  logic [7:0] Led;
  logic       playing;

  modport master (output note_in, input SPK, input Led, input playing);
  modport slave  (input note_in, output SPK, output Led, output playing);
endinterface

// File: rtl/note_tone_gen_sync.sv
// note_sync stage: two-flop resynchroniser for the asynchronous note code
// plus the accept decision.
//   clk, rst   clock and synchronous active-high reset
//   note_in    raw note code from the slow beat domain
//   cur_note   note currently held by the FSM (already normalised)
//   acc_pulse  high for the cycle in which a new code is to be taken
//   acc_note   normalised code to take (9..15 folded to none)
// A code is accepted only when both flops agree, so a code that is still
// changing (or a one-cycle blip) never reaches the FSM.
module note_tone_gen_sync
  import note_tone_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] note_in,
  input  logic [3:0] cur_note,
  output logic       acc_pulse,
  output logic [3:0] acc_note
);

  logic [3:0] s0;
  logic [3:0] s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= note_in;
      s1 <= s0;
    end
  end

  // Comparing the normalised code keeps an out-of-range code from being
  // re-accepted every cycle while already silent.
  always_comb begin
    acc_note  = note_norm(s1);
    acc_pulse = (s1 == s0) && (acc_note != cur_note);
  end

endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: square-wave tone generator for the piezo/audio pin.
// Ports:
//   CLK    system clock (100 MHz)
//   RESET  synchronous, active-high reset
//   bus    note_tone_gen_if.slave: note_in in, SPK/Led/playing out
// Parameters:
//   CNT_W      half-period counter width
//   DIV_SHIFT  right shift applied to the half-period table (simulation speed-up)
//   GAP_CYC    silence length between consecutive notes when the gap is built in
// Build option: define TONE_GAP_EN to insert GAP_CYC cycles of silence when
// one valid note follows another while sounding.
module note_tone_gen
  import note_tone_gen_pkg::*;
#(
  parameter int CNT_W     = 18,
  parameter int DIV_SHIFT = 0,
  parameter int GAP_CYC   = 2_000_000
) (
  input logic              CLK,
  input logic              RESET,
  note_tone_gen_if.slave   bus
);

  // One counter times both half-periods and the inter-note gap, so it is
  // wide enough for whichever is longer; unused upper bits are constant.
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int CW    = (CNT_W > GAP_W) ? CNT_W : GAP_W;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    cur_note, cur_n;
  logic          spk_q, spk_n;
  logic [7:0]    led_q, led_n;
  logic          playing_q, playing_n;

  logic          acc_pulse;
  logic [3:0]    acc_note;
  logic [CNT_W-1:0] h;
  logic [CW-1:0] h_last;

  note_tone_gen_sync u_sync (
    .clk       (CLK),
    .rst       (RESET),
    .note_in   (bus.note_in),
    .cur_note  (cur_note),
    .acc_pulse (acc_pulse),
    .acc_note  (acc_note)
  );

  // Half-period always follows the accepted note, never the raw sync output.
  assign h      = CNT_W'(half_period(cur_note) >> DIV_SHIFT);
  assign h_last = CW'(h) - CW'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur_note;
    spk_n   = spk_q;
    case (state)
      ST_TONE: begin
        if (cnt == h_last) begin
          cnt_n = '0;
          spk_n = ~spk_q;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef TONE_GAP_EN
      ST_GAP: begin
        spk_n = 1'b0;
        if (cnt == CW'(GAP_CYC - 1)) begin
          state_n = ST_TONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      default: begin
        spk_n = 1'b0;
        cnt_n = '0;
      end
    endcase

    // A newly accepted code always restarts the waveform from low.
    if (acc_pulse) begin
      cur_n = acc_note;
      cnt_n = '0;
      spk_n = 1'b0;
      if (acc_note == NOTE_NONE) begin
        state_n = ST_SILENT;
      end
`ifdef TONE_GAP_EN
      else if (state != ST_SILENT) begin
        state_n = ST_GAP;
      end
`endif
      else begin
        state_n = ST_TONE;
      end
    end

    playing_n = (state_n == ST_TONE);
    led_n     = playing_n ? note_led(cur_n) : 8'd0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_SILENT;
      cnt       <= '0;
      cur_note  <= NOTE_NONE;
      spk_q     <= 1'b0;
      led_q     <= 8'd0;
      playing_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cur_note  <= cur_n;
      spk_q     <= spk_n;
      led_q     <= led_n;
      playing_q <= playing_n;
    end
  end

  assign bus.SPK     = spk_q;
  assign bus.Led     = led_q;
  assign bus.playing = playing_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen with DIV_SHIFT=10 and GAP_CYC=50.
// Effective half-periods: C4 186, D 166, E 148, F 139, G 124, A 110, B 98, C5 93.
module tb_note_tone_gen;

  localparam int CNT_W     = 18;
  localparam int DIV_SHIFT = 10;
  localparam int GAP_CYC   = 50;
`ifdef TONE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_tone_gen_if tif ();

  note_tone_gen #(
    .CNT_W     (CNT_W),
    .DIV_SHIFT (DIV_SHIFT),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (tif)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: which note is accepted when, and how long it has sounded.
  int unsigned hp_tab [9] = '{0, 191113, 170265, 151685, 143172, 127551, 113636, 101239, 95557};
  int m_s0, m_s1;       // note_in seen at the previous two edges
  int m_cur;            // accepted note, 0 = none
  int m_state;          // 0 silent, 1 tone, 2 gap
  int m_t;              // edges since the tone started
  int m_gap;            // edges spent in the gap

  function automatic int norm(input int v);
    return (v >= 1 && v <= 8) ? v : 0;
  endfunction

  function automatic int hcyc(input int n);
    return int'(hp_tab[n] >> DIV_SHIFT);
  endfunction

  task automatic model_step();
    int  n;
    bit  acc;
    if (rst) begin
      m_s0 = 0; m_s1 = 0; m_cur = 0; m_state = 0; m_t = 0; m_gap = 0;
    end else begin
      n   = norm(m_s1);
      acc = (m_s1 == m_s0) && (n != m_cur);
      if (acc) begin
        m_cur = n;
        if (n == 0) m_state = 0;
        else if (GAP_EN && m_state != 0) begin m_state = 2; m_gap = 0; end
        else begin m_state = 1; m_t = 0; end
      end else if (m_state == 1) begin
        m_t++;
      end else if (m_state == 2) begin
        m_gap++;
        if (m_gap == GAP_CYC) begin m_state = 1; m_t = 0; end
      end
      m_s1 = m_s0;
      m_s0 = int'(tif.note_in);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    logic [31:0] e_spk, e_led, e_play;
    e_play = (m_state == 1) ? 1 : 0;
    e_spk  = (m_state == 1) ? ((m_t / hcyc(m_cur)) % 2) : 0;
    e_led  = (m_state == 1) ? (32'd1 << (m_cur - 1)) : 0;
    chk("model_spk", tif.SPK, e_spk);
    chk("model_led", tif.Led, e_led);
    chk("model_playing", tif.playing, e_play);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    tif.note_in = 4'd0;
    fork
      forever begin @(posedge clk); model_step(); end
      forever begin @(negedge clk); if (chk_en) compare(); end
    join_none

    edges(3);
    chk_en = 1'b1;
    chk("rst_spk", tif.SPK, 0);
    chk("rst_led", tif.Led, 0);
    chk("rst_playing", tif.playing, 0);
    chk("rst_cnt", dut.cnt, 0);
    rst = 1'b0;

    // E from silence: accepted at edge 3, rises at 151, falls at 299
    tif.note_in = 4'd3;
    edges(2);
    chk("t1_not_yet", tif.playing, 0);
    edges(1);
    chk("t1_led", tif.Led, 8'b0000_0100);
    chk("t1_playing", tif.playing, 1);
    chk("t1_spk_acc", tif.SPK, 0);
    edges(147);
    chk("t1_spk_150", tif.SPK, 0);
    edges(1);
    chk("t1_spk_151", tif.SPK, 1);
    edges(147);
    chk("t1_spk_298", tif.SPK, 1);
    edges(1);
    chk("t1_spk_299", tif.SPK, 0);

    // E -> none
    tif.note_in = 4'd0;
    edges(2);
    chk("t2_still", tif.playing, 1);
    edges(1);
    chk("t2_spk", tif.SPK, 0);
    chk("t2_led", tif.Led, 0);
    chk("t2_playing", tif.playing, 0);
    edges(20);
    chk("t2_cnt", dut.cnt, 0);

    // C4 then C5 mid-half-period
    tif.note_in = 4'd1;
    edges(3);
    chk("t3_led_c4", tif.Led, 8'b0000_0001);
    edges(200);
    chk("t3_spk_c4", tif.SPK, 1);
    tif.note_in = 4'd8;
    edges(2);
    chk("t3_spk_pre", tif.SPK, 1);
    edges(1);
    chk("t3_spk_acc", tif.SPK, 0);
    chk("t3_led_c5", tif.Led, 8'b1000_0000);
    chk("t3_cnt", dut.cnt, 0);
    edges(92);
    chk("t3_spk_92", tif.SPK, 0);
    edges(1);
    chk("t3_spk_93", tif.SPK, 1);

    // code 12 behaves as none
    tif.note_in = 4'd12;
    edges(3);
    chk("t4_spk", tif.SPK, 0);
    chk("t4_led", tif.Led, 0);
    edges(300);
    chk("t4_spk_late", tif.SPK, 0);
    chk("t4_playing", tif.playing, 0);

    // one-cycle G blip while E sounds
    tif.note_in = 4'd3;
    edges(13);
    tif.note_in = 4'd5;
    edges(1);
    tif.note_in = 4'd3;
    edges(6);
    chk("t5_led", tif.Led, 8'b0000_0100);
    chk("t5_spk_17", tif.SPK, 0);
    edges(131);
    chk("t5_spk_148", tif.SPK, 1);

    // reset while SPK is high
    rst = 1'b1;
    edges(1);
    chk("t6_spk", tif.SPK, 0);
    chk("t6_led", tif.Led, 0);
    chk("t6_playing", tif.playing, 0);
    rst = 1'b0;
    edges(3);
    chk("t6_reacc", tif.Led, 8'b0000_0100);

    // E -> F
    tif.note_in = 4'd4;
    edges(3);
`ifdef TONE_GAP_EN
    chk("t7_gap_led", tif.Led, 0);
    chk("t7_gap_play", tif.playing, 0);
    edges(49);
    chk("t7_gap_end", tif.playing, 0);
    edges(1);
    chk("t7_f_led", tif.Led, 8'b0000_1000);
`else
    chk("t7_f_led", tif.Led, 8'b0000_1000);
    chk("t7_f_play", tif.playing, 1);
`endif
    chk("t7_spk0", tif.SPK, 0);
    edges(138);
    chk("t7_spk_138", tif.SPK, 0);
    edges(1);
    chk("t7_spk_139", tif.SPK, 1);

    edges(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
